basic_splitter: RTL and testbench
=================================

BASIC_SPLITTER -- requirements
Module: basic_splitter

Interface
REQ-001 Parameter DELAY, default 1: base latency in clock cycles from `in` to both outputs, legal range 1..16.
REQ-002 Parameter SKEW2, default 0: extra cycles of latency on out2 only, legal range 0..15.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port in, input, 1 bit: the signal to be split; sampled every rising clk edge.
REQ-006 Port out1, output, 1 bit: first copy of `in`; registered.
REQ-007 Port out2, output, 1 bit: second copy of `in`; registered.

Function
REQ-008 The sampled `in` value SHALL feed a shift chain; out1 SHALL equal `in` as sampled DELAY rising edges earlier.
REQ-009 out2 SHALL equal `in` as sampled DELAY+SKEW2 rising edges earlier.
REQ-010 With SKEW2=0, out1 and out2 SHALL be identical on every cycle.
REQ-011 Every input level change SHALL reach each output exactly once: no dropped, duplicated or merged events, including changes on consecutive cycles.
REQ-012 Outputs SHALL be driven directly from flops, with no combinational path from `in` to out1 or out2.
REQ-013 Parameter values outside their legal range SHALL cause an elaboration-time error.

Reset
REQ-014 While rst_n=0 at a rising edge, out1, out2 and all delay-chain stages SHALL load 0; `in` is ignored in that cycle.
REQ-015 The first edge with rst_n=1 SHALL sample `in`. That value SHALL appear on out1 after DELAY edges and on out2 after DELAY+SKEW2 edges. Outputs stay 0 until then.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight values; no pre-reset value SHALL appear on any output after reset.

Configuration
REQ-017 Macro BASIC_SPLITTER_PULSE_EN undefined: level mode as specified in REQ-008..REQ-011.
REQ-018 Macro BASIC_SPLITTER_PULSE_EN defined: each input transition, 0->1 or 1->0, SHALL produce a single-cycle 1 pulse on each output at the latency of REQ-008/REQ-009; outputs are 0 otherwise.
REQ-019 In pulse mode, the previous-input register SHALL reset to 0, so `in`=1 on the first post-reset edge counts as a transition.
REQ-020 In pulse mode, transitions on consecutive cycles SHALL produce consecutive pulses, one cycle each.

Structure
REQ-021 Package basic_splitter_pkg SHALL hold DELAY_DEFAULT=1, SKEW2_DEFAULT=0, DELAY_MAX=16, SKEW_MAX=15 and the mode typedef (LEVEL, PULSE).
REQ-022 Sub-module split_delay_line (parameter DEPTH, 1-bit data, clk and rst_n) SHALL implement each delay chain.
REQ-023 basic_splitter SHALL instantiate split_delay_line twice:
- one of depth DELAY, driving out1;
- one of depth SKEW2, driving out2 from the out1 chain output; depth 0 is a wire-through, so out2 equals out1.

Verification
REQ-024 Defaults, reset then `in`=0 for 2 cycles then `in`=1 -> out1=out2=0 until 1 edge after the first `in`=1 sample, then both 1 on the same cycle.
REQ-025 DELAY=3, SKEW2=2, pattern 1,0,1,1,0 -> out1 reproduces the pattern 3 cycles late; out2 reproduces it 5 cycles late.
REQ-026 Reset asserted for 1 cycle while a 1 is in flight (DELAY=4) -> out1 and out2 remain 0 for 4 cycles after reset release.
REQ-027 BASIC_SPLITTER_PULSE_EN defined, defaults, `in` toggled once (0->1) at cycle 10 -> exactly one 1-cycle pulse on out1 and on out2 at cycle 11; no other pulses over 30 cycles.
REQ-028 BASIC_SPLITTER_PULSE_EN defined, `in` toggled every cycle for 8 cycles -> 8 back-to-back pulses on each output, i.e. outputs held 1 for 8 consecutive cycles.
REQ-029 Random `in` for 10000 cycles (DELAY=2, SKEW2=1) against a reference model -> zero mismatches and out1 transition count equal to input transition count.

Source files
------------

// File: rtl/basic_splitter_pkg.sv
// -----------------------------------------------------------------------------
// basic_splitter_pkg
// Shared constants and types for the basic_splitter block.
//   DELAY_DEFAULT / SKEW2_DEFAULT : default latencies of the splitter
//   DELAY_MAX / SKEW_MAX          : upper bounds of the legal parameter ranges
//   split_mode_e                  : LEVEL (copy levels) or PULSE (mark edges)
// -----------------------------------------------------------------------------
package basic_splitter_pkg;

    localparam int DELAY_DEFAULT = 1;
    localparam int SKEW2_DEFAULT = 0;
    localparam int DELAY_MAX     = 16;
    localparam int SKEW_MAX      = 15;

    typedef enum logic {
        LEVEL = 1'b0,
        PULSE = 1'b1
    } split_mode_e;

endpackage

// File: rtl/split_delay_line.sv
// -----------------------------------------------------------------------------
// split_delay_line
// 1-bit shift chain of DEPTH flops with synchronous active-low reset.
// DEPTH = 0 is a plain wire-through (q = d), used for a zero skew.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears every stage
//   d     : data into the first stage
//   q     : last stage (or d when DEPTH = 0)
// -----------------------------------------------------------------------------
module split_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (DEPTH < 0) begin : g_bad_depth
        $error("split_delay_line: DEPTH must be >= 0");
    end

    if (DEPTH == 0) begin : g_wire
        // No stages: clock and reset are not needed on this path.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign q = d;
    end else begin : g_chain
        logic [DEPTH-1:0] stages;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stages <= '0;
            end else begin
                stages[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign q = stages[DEPTH-1];
    end

endmodule

// File: rtl/basic_splitter.sv
// -----------------------------------------------------------------------------
// basic_splitter
// Splits one input into two registered copies. out1 lags `in` by DELAY
// clocks, out2 lags out1 by a further SKEW2 clocks.
// Configuration macro BASIC_SPLITTER_PULSE_EN:
//   undefined : level mode, outputs reproduce the input level
//   defined   : pulse mode, every input transition becomes a 1-cycle pulse
// Parameters:
//   DELAY : base latency, 1..DELAY_MAX
//   SKEW2 : extra latency on out2, 0..SKEW_MAX
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   in    : signal to split
//   out1  : delayed copy (DELAY)
//   out2  : delayed copy (DELAY + SKEW2)
// -----------------------------------------------------------------------------
module basic_splitter
    import basic_splitter_pkg::*;
#(
    parameter int DELAY = DELAY_DEFAULT,
    parameter int SKEW2 = SKEW2_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out1,
    output logic out2
);

`ifdef BASIC_SPLITTER_PULSE_EN
    localparam split_mode_e MODE = PULSE;
`else
    localparam split_mode_e MODE = LEVEL;
`endif

    if (DELAY < 1 || DELAY > DELAY_MAX) begin : g_bad_delay
        $error("basic_splitter: DELAY out of range 1..%0d", DELAY_MAX);
    end
    if (SKEW2 < 0 || SKEW2 > SKEW_MAX) begin : g_bad_skew
        $error("basic_splitter: SKEW2 out of range 0..%0d", SKEW_MAX);
    end

    logic chain_in;

    if (MODE == PULSE) begin : g_pulse
        // prev_in clears on reset, so a 1 on the first sampled edge
        // after reset is seen as a 0->1 transition.
        logic prev_in;

        always_ff @(posedge clk) begin
            if (!rst_n) prev_in <= 1'b0;
            else        prev_in <= in;
        end

        // Transition marker is registered by the first chain stage, so
        // outputs stay flop-driven.
        assign chain_in = in ^ prev_in;
    end else begin : g_level
        assign chain_in = in;
    end

    split_delay_line #(.DEPTH(DELAY)) u_base (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (chain_in),
        .q     (out1)
    );

    // out2 extends the out1 chain, so the two copies can never diverge
    // beyond the fixed skew.
    split_delay_line #(.DEPTH(SKEW2)) u_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (out1),
        .q     (out2)
    );

endmodule

// File: tb/tb_basic_splitter.sv
// -----------------------------------------------------------------------------
// tb_basic_splitter
// Four splitter configurations driven by one shared stimulus stream:
//   u_a defaults, u_b DELAY=3/SKEW2=2, u_c DELAY=4, u_d DELAY=2/SKEW2=1.
// Expected outputs come from hand-written vector tables and from a
// history-queue model of "output = event from N edges ago".
// -----------------------------------------------------------------------------
module tb_basic_splitter;

`ifdef BASIC_SPLITTER_PULSE_EN
    localparam bit PULSE_MODE = 1'b1;
`else
    localparam bit PULSE_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in = 1'b0;
    logic a1, a2, b1, b2, c1, c2, d1, d2;

    always #5 clk = ~clk;

    basic_splitter u_a (.clk(clk), .rst_n(rst_n), .in(in), .out1(a1), .out2(a2));
    basic_splitter #(.DELAY(3), .SKEW2(2)) u_b (.clk(clk), .rst_n(rst_n), .in(in), .out1(b1), .out2(b2));
    basic_splitter #(.DELAY(4), .SKEW2(0)) u_c (.clk(clk), .rst_n(rst_n), .in(in), .out1(c1), .out2(c2));
    basic_splitter #(.DELAY(2), .SKEW2(1)) u_d (.clk(clk), .rst_n(rst_n), .in(in), .out1(d1), .out2(d2));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: ev[k] is the event entering the splitter k edges ago
    // (ev[0] = most recent edge). Level mode: the sampled level. Pulse
    // mode: 1 when the sample differs from the previous sample.
    logic ev[$];
    logic prev_samp = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v);
        if (!r) begin
            ev.delete();
            for (int k = 0; k < 32; k++) ev.push_back(1'b0);
            prev_samp = 1'b0;
        end else begin
            ev.push_front(PULSE_MODE ? (v ^ prev_samp) : v);
            void'(ev.pop_back());
            prev_samp = v;
        end
    endtask

    // One clock: apply inputs, clock edge, then compare every DUT with the model.
    task automatic tick(input logic r, input logic v);
        rst_n = r;
        in    = v;
        @(posedge clk);
        model_step(r, v);
        #1;
        chk("model_a1", a1, ev[0]);
        chk("model_a2", a2, ev[0]);
        chk("model_b1", b1, ev[2]);
        chk("model_b2", b2, ev[4]);
        chk("model_c1", c1, ev[3]);
        chk("model_c2", c2, ev[3]);
        chk("model_d1", d1, ev[1]);
        chk("model_d2", d2, ev[2]);
    endtask

    typedef struct {
        logic r;
        logic i;
        logic ea;
        logic eb1;
        logic eb2;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [0:11] s_v, a_v, b1_v, b2_v;
        logic exp_a, last_out;
        int   cnt_ev, cnt_in, cnt_out;
        logic v, prev_v;

        for (int k = 0; k < 32; k++) ev.push_back(1'b0);

        // Post-reset stimulus 0,0 then 1,0,1,1,0 then zeros.
        s_v = 12'b0010_1100_0000;
        if (PULSE_MODE) begin
            a_v  = 12'b0011_1010_0000;
            b1_v = 12'b0000_1110_1000;
            b2_v = 12'b0000_0011_1010;
        end else begin
            a_v  = 12'b0010_1100_0000;
            b1_v = 12'b0000_1011_0000;
            b2_v = 12'b0000_0010_1100;
        end

        // Reset rows drive in=1, which must be ignored.
        tbl.push_back('{r: 1'b0, i: 1'b1, ea: 1'b0, eb1: 1'b0, eb2: 1'b0});
        tbl.push_back('{r: 1'b0, i: 1'b1, ea: 1'b0, eb1: 1'b0, eb2: 1'b0});
        for (int n = 0; n < 12; n++)
            tbl.push_back('{r: 1'b1, i: s_v[n], ea: a_v[n], eb1: b1_v[n], eb2: b2_v[n]});

        foreach (tbl[k]) begin
            tick(tbl[k].r, tbl[k].i);
            chk("tbl_a1", a1, tbl[k].ea);
            chk("tbl_a2", a2, tbl[k].ea);
            chk("tbl_b1", b1, tbl[k].eb1);
            chk("tbl_b2", b2, tbl[k].eb2);
        end

        // Reset pulse while a 1 is travelling down the DELAY=4 chain.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            tick(1'b1, 1'b0);
            chk("flush_c1", c1, 1'b0);
            chk("flush_c2", c2, 1'b0);
        end

        // Single 0->1 step at post-reset edge 10, watched for 30 edges.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        cnt_ev = 0;
        last_out = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick(1'b1, (n >= 10));
            exp_a = PULSE_MODE ? (n == 10) : (n >= 10);
            chk("step_a1", a1, exp_a);
            chk("step_a2", a2, exp_a);
            if (PULSE_MODE ? a1 : (a1 != last_out)) cnt_ev++;
            last_out = a1;
        end
        chk("step_events", (cnt_ev == 1), 1'b1);

        // Eight consecutive toggles on edges 2..9.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        cnt_ev = 0;
        last_out = 1'b0;
        for (int n = 0; n < 14; n++) begin
            v = (n >= 2 && n <= 9) ? ((n % 2) == 0) : 1'b0;
            tick(1'b1, v);
            exp_a = PULSE_MODE ? (n >= 2 && n <= 9) : v;
            chk("toggle_a1", a1, exp_a);
            chk("toggle_a2", a2, exp_a);
            if (PULSE_MODE ? a1 : (a1 != last_out)) cnt_ev++;
            last_out = a1;
        end
        chk("toggle_events", (cnt_ev == 8), 1'b1);

        // Random stream; u_d output events must match input transitions.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        cnt_in = 0;
        cnt_out = 0;
        prev_v = 1'b0;
        last_out = 1'b0;
        v = 1'b0;
        for (int n = 0; n < 10004; n++) begin
            if (n < 10000) v = 1'($urandom % 2);
            if (v != prev_v) cnt_in++;
            prev_v = v;
            tick(1'b1, v);
            if (PULSE_MODE ? d1 : (d1 != last_out)) cnt_out++;
            last_out = d1;
        end
        if (cnt_out != cnt_in) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rand_events: out1 events %0d, input transitions %0d", cnt_out, cnt_in);
        end else begin
            n_cmp++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
